// File: rtl/xnor_lfsr.sv
// Fibonacci LFSR / PRBS source with XNOR feedback, valid/ready output,
// period tracking (COUNT/WRAP) and rejection of the all-ones lock-up seed.
module xnor_lfsr #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hB8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] SEED,
  input  logic             READY,
  output logic             VALID,
  output logic [WIDTH-1:0] OUT0,
  output logic             BIT_OUT,
  output logic [WIDTH-1:0] COUNT,
  output logic             WRAP,
  output logic             SEED_ERR
);

  localparam logic [WIDTH-1:0] ONES = '1;

  if (WIDTH < 3 || WIDTH > 32) begin : g_width_chk
    $error("xnor_lfsr: WIDTH must be in 3..32");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_taps_chk
    $error("xnor_lfsr: TAPS must include the top state bit");
  end

  // All-ones is the XNOR fixed point; escape it to zero instead of shifting.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    if (s == ONES) return '0;
    return {s[WIDTH-2:0], ~^(s & TAPS)};
  endfunction

  logic [WIDTH-1:0] state_p0;
  logic [WIDTH-1:0] seed_p0;
  logic [WIDTH-1:0] cnt_p0;
  logic             vld_p0;
  logic             wrap_p0;
  logic             err_p0;
  logic [WIDTH-1:0] nxt;

  assign nxt = lfsr_next(state_p0);

  // Stage p0: LFSR state, handshake and period tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p0 <= '0;
      seed_p0  <= '0;
      cnt_p0   <= '0;
      vld_p0   <= 1'b0;
      wrap_p0  <= 1'b0;
      err_p0   <= 1'b0;
    end else begin
      wrap_p0 <= 1'b0;
      err_p0  <= 1'b0;
      if (LOAD) begin
        if (SEED == ONES) begin
          state_p0 <= '0;
          seed_p0  <= '0;
          err_p0   <= 1'b1;
        end else begin
          state_p0 <= SEED;
          seed_p0  <= SEED;
        end
        vld_p0 <= 1'b0;
        cnt_p0 <= '0;
      end else if (!vld_p0) begin
        // First word after (re)start is the seed itself.
        if (EN) vld_p0 <= 1'b1;
      end else if (READY) begin
        state_p0 <= nxt;
        vld_p0   <= EN;
        if (nxt == seed_p0) begin
          cnt_p0  <= '0;
          wrap_p0 <= 1'b1;
        end else begin
          cnt_p0 <= cnt_p0 + WIDTH'(1);
        end
      end
    end
  end

  assign VALID    = vld_p0;
  assign OUT0     = state_p0;
  assign BIT_OUT  = state_p0[WIDTH-1];
  assign COUNT    = cnt_p0;
  assign WRAP     = wrap_p0;
  assign SEED_ERR = err_p0;

endmodule

// File: doc/xnor_lfsr.md
Name: xnor_lfsr

Overview:
Parameterized Fibonacci LFSR / PRBS generator whose feedback is the XNOR reduction of the tapped state bits. It is the sequential stage built around the basic XNOR gate, which forms its feedback path. It supplies pseudo-random words to downstream test and scrambler logic over a valid/ready handshake. It also tracks the sequence period and rejects the XNOR lock-up seed.

Parameters:
WIDTH, 8, LFSR length in bits; legal range 3..32.
TAPS, 8'hB8, feedback tap mask (WIDTH bits); bit i = 1 puts state bit i in the feedback; bit WIDTH-1 must be 1.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  generation enable.
LOAD  input  1  load SEED into state (one-cycle strobe).
SEED  input  WIDTH  seed value, sampled when LOAD=1.
READY  input  1  downstream accepts OUT0 this cycle.
VALID  output  1  OUT0 holds a word to be consumed.
OUT0  output  WIDTH  current LFSR state.
BIT_OUT  output  1  OUT0[WIDTH-1], serial PRBS bit.
COUNT  output  WIDTH  advances since last seed/reset, wraps per period.
WRAP  output  1  one-cycle pulse: sequence returned to seed.
SEED_ERR  output  1  one-cycle pulse: all-ones seed rejected.

Behaviour:
- Reset (RST=1 at edge): state=0, seed_reg=0, VALID=0, COUNT=0, WRAP=0, SEED_ERR=0. RST beats every other input, including mid-handshake.
- Feedback: fb = ~^(state & TAPS); next = {state[WIDTH-2:0], fb}. All-ones is the XNOR lock-up state, so all-zero is the legal start state.
- Priority per cycle: RST > LOAD > handshake/advance.
- LOAD=1:
  - If SEED != all-ones: state=SEED, seed_reg=SEED.
  - If SEED == all-ones: state=0, seed_reg=0, SEED_ERR=1 for the next cycle only.
  - In both cases VALID=0, COUNT=0, WRAP=0, and any pending handshake is discarded.
- Handshake follows valid/ready rules. A transfer occurs in a cycle where VALID && READY.
  - VALID=0, EN=1: VALID<=1 with state unchanged, so the first word presented is the seed.
  - VALID=0, EN=0: idle; nothing changes.
  - VALID=1, READY=0: stall. OUT0 and VALID hold regardless of EN; VALID never drops without a transfer.
  - VALID=1, READY=1: state<=next and VALID<=EN. With EN held high, one word transfers per cycle (zero-bubble throughput).
- COUNT/WRAP:
  - On each transfer, COUNT<=COUNT+1 (modulo 2^WIDTH).
  - If next == seed_reg, COUNT<=0 and WRAP<=1 for one cycle instead.
  - WRAP is 0 in every other cycle.
- Lock-up safety: if state is ever all-ones (for example, a corrupt state), the next advance forces state=0 instead of applying the shift.
- Latency: OUT0 changes 1 cycle after a transfer edge; WRAP and SEED_ERR are registered, 1 cycle after the causing edge.
- BIT_OUT is combinational from state.

Test Plan:
1. WIDTH=4, TAPS=4'b1100, reset, then EN=1, READY=1 -> OUT0 sequence 0,0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0 (the first 0 is the pre-VALID cycle). WRAP pulses with the return to 0 (15 transfers) and COUNT reads 0 after the wrap.
2. Same config, READY toggled 1,0,0,1 while VALID=1 -> OUT0 frozen and VALID held through the two stall cycles. No word skipped or duplicated; COUNT increments only on transfers.
3. LOAD with SEED=4'hF -> next cycle state=0, SEED_ERR=1 for exactly one cycle, VALID=0.
4. LOAD with SEED=4'h9 while VALID=1, READY=0 -> state=9, VALID=0, COUNT=0. After EN=1 the first word presented is 9, and WRAP fires after 15 transfers when the state returns to 9.
5. RST=1 asserted mid-stream (state=B, VALID=1) together with LOAD=1 -> state=0, VALID=0, COUNT=0, no SEED_ERR or WRAP pulse. Reset wins over LOAD.
6. EN dropped on a transfer cycle (VALID=1, READY=1, EN=0) -> state advances once, VALID=0 next cycle, state then holds.
